// File: rtl/fsm_pkg.sv
// Shared definitions for the serial pattern transmitter and its sequence-FSM siblings.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

    // A length of zero or beyond the register width means "send the full width".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/fsm_bit_timer.sv
// Wrapping period counter: tick marks the last cycle of each period.
module fsm_bit_timer #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] period,
    output logic          tick
);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == period - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: parallel pattern in over valid/ready, MSB-of-length first out.
module fsm_pattern_tx
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_DIV    = 1,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic [$clog2(WIDTH+1)-1:0] tx_len,
    input  logic                       abort,
    output logic                       ser_out,
    output logic                       ser_en,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TMAX = (BIT_DIV > GAP_CYCLES) ? BIT_DIV : GAP_CYCLES;
    localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam logic [CW-1:0] BIT_P = CW'(BIT_DIV);
    localparam logic [CW-1:0] GAP_P = CW'(GAP_CYCLES);

    tx_state_t        state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic             ser_out_n, ser_en_n, done_n;

    int unsigned      acc_len;
    logic [WIDTH-1:0] load_pat;
    logic             tick, timer_clear, timer_en;
    logic [CW-1:0]    period;

    // Left-align the pattern so the first bit to send always sits in the MSB.
    assign acc_len  = eff_len(32'(tx_len), WIDTH);
    assign load_pat = tx_data << (WIDTH - acc_len);

    assign period      = (state == GAP) ? GAP_P : BIT_P;
    assign timer_en    = (state != IDLE);
    assign timer_clear = (state == IDLE) || (state_n == IDLE);

    fsm_bit_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .period (period),
        .tick   (tick)
    );

    // Next-state logic produces next-cycle output values so every output is a flop.
    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        bit_cnt_n = bit_cnt;
        ser_out_n = IDLE_LEVEL;
        ser_en_n  = 1'b0;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready && !abort) begin
                    state_n   = SHIFT;
                    sreg_n    = load_pat;
                    bit_cnt_n = BW'(acc_len - 1);
                    ser_out_n = load_pat[WIDTH-1];
                    ser_en_n  = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (bit_cnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        sreg_n    = sreg << 1;
                        bit_cnt_n = bit_cnt - BW'(1);
                        ser_out_n = sreg_n[WIDTH-1];
                        ser_en_n  = 1'b1;
                    end
                end else begin
                    ser_out_n = sreg[WIDTH-1];
                    ser_en_n  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (tick) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            ser_out  <= IDLE_LEVEL;
            ser_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            bit_cnt  <= bit_cnt_n;
            ser_out  <= ser_out_n;
            ser_en   <= ser_en_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            tx_ready <= (state_n == IDLE);
        end
    end

endmodule
